bn_scale_pipe: RTL and testbench

BN_SCALE_PIPE -- requirements
Module: bn_scale_pipe

---
 rtl/bn_scale_pipe.sv | 127 ++++++++++++
 tb/tb_bn_scale_pipe.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bn_scale_pipe.sv
// Two-stage FP16 per-channel scaling pipeline with valid/ready handshaking.
// S1 captures operands and the channel's scale at accept; S2 holds the product.
module bn_scale_pipe #(
   parameter int LANES  = 4,
   parameter int NUM_CH = 4,
   localparam int CW    = $clog2(NUM_CH),
   localparam int DW    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DW*LANES-1:0] x,
   input  logic                bypass,
   input  logic                ch_clear,
   input  logic                cfg_we,
   input  logic [CW-1:0]       cfg_addr,
   input  logic [DW*LANES-1:0] cfg_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DW*LANES-1:0] Out,
   output logic [CW-1:0]       out_ch
);

   logic [DW*LANES-1:0] scale [NUM_CH];
   logic [CW-1:0]       ch_cnt;
   logic                s1_valid;
   logic [DW*LANES-1:0] s1_x;
   logic [DW*LANES-1:0] s1_scale;
   logic                s1_bypass;
   logic [CW-1:0]       s1_ch;
   logic [DW*LANES-1:0] res;
   logic                accept;
   logic                s2_adv;

   // Subnormals flush to zero; zero-operand check wins over the Inf/NaN check.
   function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
      logic              s;
      logic [4:0]        ea;
      logic [4:0]        eb;
      logic [21:0]       p;
      logic [10:0]       m;
      logic              g;
      logic              st;
      logic signed [7:0] e;
      logic [15:0]       r;
      s  = a[15] ^ b[15];
      ea = a[14:10];
      eb = b[14:10];
      p  = {1'b1, a[9:0]} * {1'b1, b[9:0]};
      e  = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 8'sd15;
      if (p[21]) begin
         m  = {1'b0, p[20:11]};
         g  = p[10];
         st = |p[9:0];
         e  = e + 8'sd1;
      end else begin
         m  = {1'b0, p[19:10]};
         g  = p[9];
         st = |p[8:0];
      end
      if (g && (st || m[0])) m = m + 11'd1;
      if (m[10]) begin
         m = '0;
         e = e + 8'sd1;
      end
      if (ea == 5'd0 || eb == 5'd0)        r = {s, 15'd0};
      else if (ea == 5'd31 || eb == 5'd31) r = {s, 15'h7C00};
      else if (e <= 8'sd0)                 r = {s, 15'd0};
      else if (e >= 8'sd31)                r = {s, 15'h7C00};
      else                                 r = {s, e[4:0], m[9:0]};
      return r;
   endfunction

   assign s2_adv   = ~out_valid | out_ready;
   assign in_ready = ~(s1_valid & out_valid & ~out_ready);
   assign accept   = in_valid & in_ready;

   always_comb begin
      res = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         res[DW*i +: DW] = s1_bypass ? s1_x[DW*i +: DW]
                                     : fp16_mul(s1_x[DW*i +: DW], s1_scale[DW*i +: DW]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned c = 0; c < NUM_CH; c++) scale[c] <= {LANES{16'h3C00}};
      end else if (cfg_we && 32'(cfg_addr) < NUM_CH) begin
         scale[cfg_addr] <= cfg_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         s1_x      <= '0;
         s1_scale  <= '0;
         s1_bypass <= 1'b0;
         s1_ch     <= '0;
         out_valid <= 1'b0;
         Out       <= '0;
         out_ch    <= '0;
         ch_cnt    <= '0;
      end else begin
         if (in_ready) s1_valid <= in_valid;
         if (accept) begin
            s1_x      <= x;
            s1_scale  <= scale[ch_cnt];
            s1_bypass <= bypass;
            s1_ch     <= ch_cnt;
         end
         if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               Out    <= res;
               out_ch <= s1_ch;
            end
         end
         // A clear coinciding with an accept still tags that beat with the old count.
         if (ch_clear)    ch_cnt <= '0;
         else if (accept) ch_cnt <= (ch_cnt == CW'(NUM_CH - 1)) ? '0 : ch_cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_bn_scale_pipe.sv
// Directed bench for bn_scale_pipe: scoreboard queue filled at accept, drained at consume.
module tb_bn_scale_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] x;
   logic        bypass;
   logic        ch_clear;
   logic        cfg_we;
   logic [1:0]  cfg_addr;
   logic [63:0] cfg_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] Out;
   logic [1:0]  out_ch;

   typedef struct {
      logic [63:0] data;
      logic [1:0]  ch;
   } exp_t;

   exp_t        q[$];
   logic [1:0]  tag_log[$];
   logic [63:0] exp_data;
   logic [1:0]  model_ch;
   int          checks = 0;
   int          errors = 0;
   int          stalls = 0;
   logic        hold_prev = 1'b0;
   logic [63:0] prev_out;
   logic [1:0]  prev_ch;

   bn_scale_pipe #(.LANES(4), .NUM_CH(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .x(x),
      .bypass(bypass), .ch_clear(ch_clear), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .out_valid(out_valid), .out_ready(out_ready), .Out(Out),
      .out_ch(out_ch)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic logic [63:0] splat(input logic [15:0] v);
      return {4{v}};
   endfunction

   // Stream scales are powers of two, so the product is an exponent-field shift.
   function automatic logic [63:0] pow2(input logic [15:0] v, input int ch);
      logic [15:0] r;
      case (ch)
         0:       r = v + 16'h0400;
         1:       r = v - 16'h0400;
         2:       r = v + 16'h0800;
         default: r = v;
      endcase
      return splat(r);
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [1:0] a, input logic [63:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      cycles(1);
      cfg_we = 1'b0;
   endtask

   task automatic pulse_clear();
      ch_clear = 1'b1;
      cycles(1);
      ch_clear = 1'b0;
   endtask

   task automatic send(input logic [63:0] xv, input logic [63:0] ev, input logic bp, input logic clr);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      x = xv; exp_data = ev; bypass = bp; ch_clear = clr; in_valid = 1'b1;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      assert (acc) else begin
         errors++;
         $error("FAIL accept_timeout got %0d exp 1", acc);
      end
      in_valid = 1'b0; bypass = 1'b0; ch_clear = 1'b0;
   endtask

   // Monitor: all DUT outputs sampled mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         q.delete();
         model_ch  = 2'd0;
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            checks++;
            assert (out_valid === 1'b1 && Out === prev_out && out_ch === prev_ch) else begin
               errors++;
               $error("FAIL hold got %b/%h/%0d exp 1/%h/%0d", out_valid, Out, out_ch, prev_out, prev_ch);
            end
         end
         if (out_valid) begin
            checks++;
            assert (q.size() > 0) else begin
               errors++;
               $error("FAIL spurious_out got %h exp none", Out);
            end
            if (out_ready && q.size() > 0) begin
               e = q.pop_front();
               checks++;
               assert (Out === e.data && out_ch === e.ch) else begin
                  errors++;
                  $error("FAIL result got %h ch%0d exp %h ch%0d", Out, out_ch, e.data, e.ch);
               end
               tag_log.push_back(out_ch);
            end
         end
         checks++;
         assert (in_ready === !(q.size() == 2 && !out_ready)) else begin
            errors++;
            $error("FAIL in_ready got %b exp %b", in_ready, !(q.size() == 2 && !out_ready));
         end
         if (!in_ready) stalls++;
         hold_prev = out_valid && !out_ready;
         prev_out  = Out;
         prev_ch   = out_ch;
         if (in_valid && in_ready) begin
            q.push_back('{exp_data, model_ch});
            model_ch = ch_clear ? 2'd0 : model_ch + 2'd1;
         end else if (ch_clear) begin
            model_ch = 2'd0;
         end
      end
   end

   initial begin
      logic [1:0]  tags6 [6];
      logic [1:0]  tags4 [4];
      logic [15:0] v;
      tags6 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      tags4 = '{2'd0, 2'd1, 2'd2, 2'd0};
      reset = 1'b1; in_valid = 1'b0; x = '0; bypass = 1'b0; ch_clear = 1'b0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; out_ready = 1'b1; exp_data = '0;
      model_ch = 2'd0;
      cycles(3);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out", Out, 64'd0);
      chk("rst_out_ch", 64'(out_ch), 64'd0);
      reset = 1'b0;
      chk("ready_after_rst", 64'(in_ready), 64'd1);

      // Default scale 1.0 and two-cycle latency
      send(64'h3C00_4000_3800_C000, 64'h3C00_4000_3800_C000, 1'b0, 1'b0);
      chk("lat_cycle1", 64'(out_valid), 64'd0);
      cycles(1);
      chk("lat_cycle2", 64'(out_valid), 64'd1);
      chk("first_ch", 64'(out_ch), 64'd0);
      cycles(3);

      cfg(2'd0, splat(16'h4000));
      pulse_clear();
      send(64'h3C00_4000_3800_C000, 64'h4000_4400_3C00_C400, 1'b0, 1'b0);
      cycles(3);

      // Overflow, underflow, subnormal and infinity lanes on ch1
      cfg(2'd1, 64'h4000_3800_4000_4000);
      send(64'h7BFF_0400_0001_FC00, 64'h7C00_0000_0000_FC00, 1'b0, 1'b0);
      // Round-to-nearest-even ties and normalisation on ch2
      cfg(2'd2, 64'h3C01_3C03_3E00_3C01);
      send(64'h3E00_3E00_3E00_3C01, 64'h3E02_3E04_4080_3C02, 1'b0, 1'b0);
      cycles(3);

      cfg(2'd1, splat(16'h3800));
      cfg(2'd2, splat(16'h4400));
      pulse_clear();
      tag_log.delete();
      stalls = 0;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               v = 16'h3C00 + 16'(i * 17);
               send(splat(v), pow2(v, i % 4), 1'b0, 1'b0);
            end
         end
         begin
            cycles(2);
            out_ready = 1'b0;
            cycles(3);
            out_ready = 1'b1;
         end
      join
      cycles(6);
      chk("stream_count", 64'(tag_log.size()), 64'd6);
      for (int i = 0; i < 6 && i < tag_log.size(); i++) chk("stream_tag", 64'(tag_log[i]), 64'(tags6[i]));
      chk("stream_stalled", 64'(stalls > 0), 64'd1);
      chk("stream_drained", 64'(q.size()), 64'd0);

      pulse_clear();
      tag_log.delete();
      for (int i = 0; i < 4; i++) begin
         v = 16'h3C40 + 16'(i * 3);
         send(splat(v), pow2(v, int'(tags4[i])), 1'b0, (i == 2));
      end
      cycles(6);
      chk("clear_count", 64'(tag_log.size()), 64'd4);
      for (int i = 0; i < 4 && i < tag_log.size(); i++) chk("clear_tag", 64'(tag_log[i]), 64'(tags4[i]));

      // Write to ch0 coincides with the ch0 accept: old scale 2.0 applies
      pulse_clear();
      cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = splat(16'h4400);
      send(splat(16'h3C00), splat(16'h4000), 1'b0, 1'b0);
      cfg_we = 1'b0;
      send(64'h7BFF_0001_FC00_1234, 64'h7BFF_0001_FC00_1234, 1'b1, 1'b0);
      cycles(3);
      pulse_clear();
      send(splat(16'h3C00), splat(16'h4400), 1'b0, 1'b0);
      cycles(3);

      // Reset with two beats in flight
      out_ready = 1'b0;
      send(splat(16'h3C00), splat(16'h1111), 1'b0, 1'b0);
      send(splat(16'h3C00), splat(16'h2222), 1'b0, 1'b0);
      reset = 1'b1;
      cycles(2);
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_out", Out, 64'd0);
      chk("midrst_out_ch", 64'(out_ch), 64'd0);
      reset = 1'b0;
      out_ready = 1'b1;
      chk("midrst_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < 4; i++) begin
         cycles(1);
         chk("no_stale", 64'(out_valid), 64'd0);
      end
      // Scales are back to 1.0 after reset
      send(splat(16'h4000), splat(16'h4000), 1'b0, 1'b0);
      cycles(4);
      chk("final_drained", 64'(q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
